// File: rtl/ram_march_bist.sv
// ram_march_bist
//    March C- built-in self-test initiator for one port of a single-clock RAM.
//    The RAM writes when ram_en is high. When ram_en is low it registers
//    read data, which appears one cycle after the address.
//    On a start pulse the block runs the six march elements M0..M5 over the
//    whole address space. It compares every read against the expected
//    background and reports pass/fail, the first failing location and a
//    saturating mismatch count.
//
//    Optional feature macro: BIST_STOP_ON_FAIL_EN
//       defined   : the first mismatch ends the test at once (FSM -> DONE).
//       undefined : the full sequence always runs and errors accumulate.
//
// Ports
//    clk        in   single rising-edge clock
//    rst_n      in   asynchronous active-low reset
//    start      in   launches a test when sampled high in IDLE
//    busy       out  high while a test runs
//    done       out  one-cycle pulse at test end
//    pass       out  last test ended with zero mismatches (held until start)
//    err_count  out  mismatch count, saturating at 255
//    fail_addr  out  address of the first mismatch
//    fail_got   out  data read at the first mismatch
//    fail_exp   out  data expected at the first mismatch
//    ram_en     out  RAM write enable (1 = write, 0 = read)
//    ram_addr   out  RAM address
//    ram_wdata  out  RAM write data
//    ram_rdata  in   RAM registered read data
module ram_march_bist #(
   parameter int unsigned   AW      = 5,
   parameter int unsigned   DW      = 8,
   parameter logic [DW-1:0] PATTERN = 8'h55
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [7:0]    err_count,
   output logic [AW-1:0] fail_addr,
   output logic [DW-1:0] fail_got,
   output logic [DW-1:0] fail_exp,
   output logic          ram_en,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   localparam logic [AW-1:0] ADDR_MAX = '1;

   typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;      // address of the next op to issue
   logic            phase_q, phase_d;    // M1..M4: 0 = read op, 1 = write op
   logic            drain_q, drain_d;    // M5: all reads issued, waiting for last compare

   logic            ram_en_q;
   logic [AW-1:0]   ram_addr_q;
   logic [DW-1:0]   ram_wdata_q;

   // Read tracking: stage 1 is aligned with the registered RAM request,
   // stage 2 with the cycle in which ram_rdata carries that read's data.
   logic            rd1_vld_q, rd1_last_q, rd2_vld_q, rd2_last_q;
   logic [DW-1:0]   rd1_exp_q, rd2_exp_q;
   logic [AW-1:0]   rd1_addr_q, rd2_addr_q;

   logic [7:0]      err_cnt_q, err_cnt_d;
   logic [AW-1:0]   fail_addr_q, fail_addr_d;
   logic [DW-1:0]   fail_got_q, fail_got_d;
   logic [DW-1:0]   fail_exp_q, fail_exp_d;
   logic            pass_q, pass_d;

   logic            op_vld, op_wr, op_last, inv_elem, desc_elem, running, mismatch;
   logic [DW-1:0]   op_data;

   assign running  = (state_q != S_IDLE) && (state_q != S_DONE);
   assign mismatch = running && rd2_vld_q && (ram_rdata != rd2_exp_q);

   // Sequencer: decides the op for the current cycle and advances the pointer.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      phase_d   = phase_q;
      drain_d   = drain_q;
      op_vld    = 1'b0;
      op_wr     = 1'b0;
      op_last   = 1'b0;
      op_data   = PATTERN;
      inv_elem  = (state_q == S_M2) || (state_q == S_M4);
      desc_elem = (state_q == S_M3) || (state_q == S_M4);
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_M0;
               addr_d  = '0;
               phase_d = 1'b0;
               drain_d = 1'b0;
            end
         end
         S_M0: begin
            op_vld = 1'b1;
            op_wr  = 1'b1;
            if (addr_q == ADDR_MAX) begin
               state_d = S_M1;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_M1, S_M2, S_M3, S_M4: begin
            op_vld  = 1'b1;
            op_wr   = phase_q;
            phase_d = ~phase_q;
            // M1/M3 read P then write ~P; M2/M4 read ~P then write P.
            op_data = (inv_elem ^ phase_q) ? ~PATTERN : PATTERN;
            if (phase_q) begin
               if (addr_q == (desc_elem ? '0 : ADDR_MAX)) begin
                  // Only M1 hands over to an ascending element.
                  addr_d = (state_q == S_M1) ? '0 : ADDR_MAX;
                  case (state_q)
                     S_M1:    state_d = S_M2;
                     S_M2:    state_d = S_M3;
                     S_M3:    state_d = S_M4;
                     default: state_d = S_M5;
                  endcase
               end else begin
                  addr_d = desc_elem ? addr_q - 1'b1 : addr_q + 1'b1;
               end
            end
         end
         S_M5: begin
            if (!drain_q) begin
               op_vld = 1'b1;
               if (addr_q == '0) begin
                  drain_d = 1'b1;
                  op_last = 1'b1;
               end else begin
                  addr_d = addr_q - 1'b1;
               end
            end
            if (rd2_vld_q && rd2_last_q) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (STOP_ON_FAIL && mismatch) begin
         state_d = S_DONE;
         op_vld  = 1'b0;
      end
   end

   // Result bookkeeping.
   always_comb begin
      err_cnt_d   = err_cnt_q;
      fail_addr_d = fail_addr_q;
      fail_got_d  = fail_got_q;
      fail_exp_d  = fail_exp_q;
      pass_d      = pass_q;
      if ((state_q == S_IDLE) && start) begin
         err_cnt_d   = '0;
         fail_addr_d = '0;
         fail_got_d  = '0;
         fail_exp_d  = '0;
         pass_d      = 1'b0;
      end else if (mismatch) begin
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
         // The count never returns to zero within a test, so zero marks the first error.
         if (err_cnt_q == 8'd0) begin
            fail_addr_d = rd2_addr_q;
            fail_got_d  = ram_rdata;
            fail_exp_d  = rd2_exp_q;
         end
      end
      // Resolve pass on entry to DONE so it already includes the final compare.
      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         pass_d = (err_cnt_d == 8'd0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         phase_q     <= 1'b0;
         drain_q     <= 1'b0;
         ram_en_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd1_vld_q   <= 1'b0;
         rd1_last_q  <= 1'b0;
         rd1_exp_q   <= '0;
         rd1_addr_q  <= '0;
         rd2_vld_q   <= 1'b0;
         rd2_last_q  <= 1'b0;
         rd2_exp_q   <= '0;
         rd2_addr_q  <= '0;
         err_cnt_q   <= '0;
         fail_addr_q <= '0;
         fail_got_q  <= '0;
         fail_exp_q  <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         phase_q     <= phase_d;
         drain_q     <= drain_d;
         if (op_vld) begin
            ram_en_q   <= op_wr;
            ram_addr_q <= addr_q;
            if (op_wr) begin
               ram_wdata_q <= op_data;
            end
         end else begin
            ram_en_q <= 1'b0;
         end
         rd1_vld_q   <= op_vld & ~op_wr;
         rd1_last_q  <= op_last;
         rd1_exp_q   <= op_data;
         rd1_addr_q  <= addr_q;
         rd2_vld_q   <= rd1_vld_q;
         rd2_last_q  <= rd1_last_q;
         rd2_exp_q   <= rd1_exp_q;
         rd2_addr_q  <= rd1_addr_q;
         err_cnt_q   <= err_cnt_d;
         fail_addr_q <= fail_addr_d;
         fail_got_q  <= fail_got_d;
         fail_exp_q  <= fail_exp_d;
         pass_q      <= pass_d;
      end
   end

   assign busy      = running;
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign err_count = err_cnt_q;
   assign fail_addr = fail_addr_q;
   assign fail_got  = fail_got_q;
   assign fail_exp  = fail_exp_q;
   assign ram_en    = ram_en_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: a 32x8 DUT with a behavioural RAM (optional
// stuck-at fault on bit 0 of address 7), plus a 64x8 DUT whose read data is
// tied to zero so that every compare mismatches.
module tb_ram_march_bist;
   localparam int AW    = 5;
   localparam int DW    = 8;
   localparam int DEPTH = 1 << AW;
   localparam logic [7:0] P  = 8'h55;
   localparam logic [7:0] NP = 8'hAA;
`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, start6 = 1'b0;
   always #5 clk = ~clk;

   logic          busy, done, pass, ram_en;
   logic [7:0]    err_count;
   logic [AW-1:0] fail_addr, ram_addr;
   logic [DW-1:0] fail_got, fail_exp, ram_wdata, ram_rdata;

   logic          busy6, done6, pass6, ram_en6;
   logic [7:0]    err_count6;
   logic [5:0]    fail_addr6, ram_addr6;
   logic [7:0]    fail_got6, fail_exp6, ram_wdata6;
   logic [7:0]    rdata6 = 8'h00;

   ram_march_bist #(.AW(AW), .DW(DW), .PATTERN(8'h55)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_addr(fail_addr), .fail_got(fail_got), .fail_exp(fail_exp),
      .ram_en(ram_en), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata));

   ram_march_bist #(.AW(6), .DW(8), .PATTERN(8'h55)) u_dut6 (
      .clk(clk), .rst_n(rst_n), .start(start6), .busy(busy6), .done(done6), .pass(pass6),
      .err_count(err_count6), .fail_addr(fail_addr6), .fail_got(fail_got6), .fail_exp(fail_exp6),
      .ram_en(ram_en6), .ram_addr(ram_addr6), .ram_wdata(ram_wdata6), .ram_rdata(rdata6));

   // Behavioural RAM: write when enabled, otherwise registered read.
   logic [DW-1:0] mem [DEPTH];
   bit fault_en = 1'b0;
   always @(posedge clk) begin
      if (ram_en) mem[ram_addr] <= (fault_en && ram_addr == 7) ? (ram_wdata | 8'h01) : ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0, checks = 0, k = 0;

   typedef struct {
      int         done_cyc;
      bit         pass;
      logic [7:0] err;
      logic [7:0] faddr;
      logic [7:0] fgot;
      logic [7:0] fexp;
   } exp_t;
   exp_t res_q[$];
   logic [AW+DW:0] op_q[$];

   // Expected RAM request stream of a full March C- run: {en, addr, write data or 0}.
   function automatic void gen_ops();
      for (int a = 0; a < DEPTH; a++) op_q.push_back({1'b1, AW'(a), P});
      for (int e = 1; e <= 2; e++)
         for (int a = 0; a < DEPTH; a++) begin
            op_q.push_back({1'b0, AW'(a), 8'h00});
            op_q.push_back({1'b1, AW'(a), (e == 1) ? NP : P});
         end
      for (int e = 3; e <= 4; e++)
         for (int a = DEPTH - 1; a >= 0; a--) begin
            op_q.push_back({1'b0, AW'(a), 8'h00});
            op_q.push_back({1'b1, AW'(a), (e == 3) ? NP : P});
         end
      for (int a = DEPTH - 1; a >= 0; a--) op_q.push_back({1'b0, AW'(a), 8'h00});
   endfunction

   // Call at a falling edge; start is sampled at rising edge k.
   task automatic pulse_start();
      start = 1'b1;
      k = cyc + 1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [45:0] obs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      obs = {busy, done, pass, err_count, fail_addr, fail_got, fail_exp, ram_en, ram_addr, ram_wdata};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h want=0", obs); end
      checks++;
      if ({busy6, done6, pass6, err_count6, ram_en6} !== 12'h0) begin
         errors++; $display("FAIL reset_outputs6 got=%h want=0", {busy6, done6, pass6, err_count6, ram_en6});
      end
      rst_n = 1'b1;
      @(negedge clk);
      $display("reset: outputs at reset values checked");
   endtask

   task automatic test_fault_free();
      exp_t e;
      int dc;
      bit seen;
      logic [AW+DW:0] eo, oo;
      @(negedge clk);
      op_q.delete();
      gen_ops();
      pulse_start();
      res_q.push_back('{k + 322, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0});
      seen = 0; dc = -1;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk);
         if (op_q.size() > 0) begin
            eo = op_q.pop_front();
            oo = {ram_en, ram_addr, ram_en ? ram_wdata : 8'h00};
            checks++;
            if (oo !== eo) begin errors++; $display("FAIL op cyc=%0d got=%h want=%h", cyc - k, oo, eo); end
         end
         if (done === 1'b1) begin seen = 1; dc = cyc; end
      end
      e = res_q.pop_front();
      checks++;
      if (dc != e.done_cyc) begin errors++; $display("FAIL ff_done_cycle got=%0d want=%0d", dc, e.done_cyc); end
      checks++;
      if ({pass, err_count, 3'b000, fail_addr, fail_got, fail_exp} !== {e.pass, e.err, e.faddr, e.fgot, e.fexp}) begin
         errors++;
         $display("FAIL ff_result got pass=%b err=%0d fa=%0d fg=%h fe=%h want pass=%b err=%0d",
                  pass, err_count, fail_addr, fail_got, fail_exp, e.pass, e.err);
      end
      checks++;
      if (op_q.size() != 0) begin errors++; $display("FAIL ff_ops_left got=%0d want=0", op_q.size()); end
      for (int a = 0; a < DEPTH; a++) begin
         checks++;
         if (mem[a] !== P) begin errors++; $display("FAIL ff_mem[%0d] got=%h want=%h", a, mem[a], P); end
      end
      $display("fault_free: done at +%0d pass=%b err_count=%0d", dc - k, pass, err_count);
   endtask

   task automatic test_stuck_bit();
      exp_t e;
      int dc;
      @(negedge clk);
      fault_en = 1'b1;
      pulse_start();
      res_q.push_back('{k + (STOP ? 113 : 322), 1'b0, STOP ? 8'd1 : 8'd2, 8'd7, 8'hAB, 8'hAA});
      dc = -1;
      for (int n = 0; n < 400 && dc < 0; n++) begin
         @(negedge clk);
         if (done === 1'b1) dc = cyc;
      end
      e = res_q.pop_front();
      checks++;
      if (dc != e.done_cyc) begin errors++; $display("FAIL sb_done_cycle got=%0d want=%0d", dc, e.done_cyc); end
      checks++;
      if (pass !== e.pass || err_count !== e.err) begin
         errors++; $display("FAIL sb_pass_err got pass=%b err=%0d want pass=%b err=%0d", pass, err_count, e.pass, e.err);
      end
      checks++;
      if ({3'b000, fail_addr, fail_got, fail_exp} !== {e.faddr, e.fgot, e.fexp}) begin
         errors++;
         $display("FAIL sb_first_fail got fa=%0d fg=%h fe=%h want fa=%0d fg=%h fe=%h",
                  fail_addr, fail_got, fail_exp, e.faddr, e.fgot, e.fexp);
      end
      fault_en = 1'b0;
      $display("stuck_bit: done at +%0d err_count=%0d fail_addr=%0d got=%h exp=%h",
               dc - k, err_count, fail_addr, fail_got, fail_exp);
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int dc;
      logic [45:0] obs;
      @(negedge clk);
      pulse_start();
      while (cyc < k + 200) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b want=1", busy); end
      rst_n = 1'b0;
      #1;
      obs = {busy, done, pass, err_count, fail_addr, fail_got, fail_exp, ram_en, ram_addr, ram_wdata};
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL mid_reset_outputs got=%h want=0", obs); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_start();
      res_q.push_back('{k + 322, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0});
      dc = -1;
      for (int n = 0; n < 400 && dc < 0; n++) begin
         @(negedge clk);
         if (done === 1'b1) dc = cyc;
      end
      e = res_q.pop_front();
      checks++;
      if (dc != e.done_cyc || pass !== e.pass || err_count !== e.err) begin
         errors++; $display("FAIL mid_rerun got done=%0d pass=%b err=%0d want done=%0d pass=1 err=0",
                            dc, pass, err_count, e.done_cyc);
      end
      $display("reset_mid: rerun done at +%0d pass=%b", dc - k, pass);
   endtask

   task automatic test_start_held();
      exp_t e;
      int dc, dc2, pulses, k1;
      @(negedge clk);
      start = 1'b1;
      k = cyc + 1;
      k1 = k;
      res_q.push_back('{k1 + 322, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0});
      res_q.push_back('{k1 + 646, 1'b1, 8'd0, 8'd0, 8'd0, 8'd0});
      dc = -1; pulses = 0;
      while (cyc < k1 + 330) begin
         @(negedge clk);
         if (done === 1'b1) begin pulses++; if (dc < 0) dc = cyc; end
         if (cyc == k1 + 323) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL held_idle_busy got=%b want=0", busy); end
         end
         if (cyc == k1 + 324) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL held_restart_busy got=%b want=1", busy); end
         end
      end
      start = 1'b0;
      e = res_q.pop_front();
      checks++;
      if (pulses != 1 || dc != e.done_cyc) begin
         errors++; $display("FAIL held_done got pulses=%0d at=%0d want pulses=1 at=%0d", pulses, dc, e.done_cyc);
      end
      dc2 = -1;
      for (int n = 0; n < 400 && dc2 < 0; n++) begin
         @(negedge clk);
         if (done === 1'b1) dc2 = cyc;
      end
      e = res_q.pop_front();
      checks++;
      if (dc2 != e.done_cyc || pass !== e.pass) begin
         errors++; $display("FAIL held_second_run got done=%0d pass=%b want done=%0d pass=1", dc2, pass, e.done_cyc);
      end
      $display("start_held: first done +%0d, second done +%0d", dc - k1, dc2 - k1);
   endtask

   task automatic test_saturate();
      exp_t e;
      int dc, k6;
      @(negedge clk);
      start6 = 1'b1;
      k6 = cyc + 1;
      @(negedge clk);
      start6 = 1'b0;
      res_q.push_back('{k6 + (STOP ? 67 : 642), 1'b0, STOP ? 8'd1 : 8'd255, 8'd0, 8'h00, 8'h55});
      dc = -1;
      for (int n = 0; n < 800 && dc < 0; n++) begin
         @(negedge clk);
         if (done6 === 1'b1) dc = cyc;
      end
      e = res_q.pop_front();
      checks++;
      if (dc != e.done_cyc) begin errors++; $display("FAIL sat_done_cycle got=%0d want=%0d", dc, e.done_cyc); end
      checks++;
      if (err_count6 !== e.err || pass6 !== e.pass) begin
         errors++; $display("FAIL sat_err got err=%0d pass=%b want err=%0d pass=0", err_count6, pass6, e.err);
      end
      checks++;
      if ({2'b00, fail_addr6, fail_got6, fail_exp6} !== {e.faddr, e.fgot, e.fexp}) begin
         errors++; $display("FAIL sat_first_fail got fa=%0d fg=%h fe=%h want fa=0 fg=00 fe=55",
                            fail_addr6, fail_got6, fail_exp6);
      end
      checks++;
      if ({ram_en6, ram_addr6, ram_wdata6} !== {1'b0, 6'd0, STOP ? NP : P}) begin
         errors++; $display("FAIL sat_ram_side got en=%b addr=%0d wd=%h", ram_en6, ram_addr6, ram_wdata6);
      end
      $display("saturate: done at +%0d err_count=%0d fail_addr=%0d", dc - k6, err_count6, fail_addr6);
   endtask

   initial begin
      for (int a = 0; a < DEPTH; a++) mem[a] = 8'h00;
      test_reset();
      test_fault_free();
      test_stuck_bit();
      test_reset_mid();
      test_start_held();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

March-test built-in self-test initiator for one port of the team's single-clock RAM (write when enable is high, registered read-data one cycle after address when enable is low). On a start pulse it drives the port with a March C- sequence, compares every read against the expected background, and reports pass/fail, the first failing location and an error count. It sits between the test/control logic and the RAM port mux. Functional traffic must not use the port while `busy` is high.

## Interface
- `AW`, 5: RAM address width; depth = 2^AW.
- `DW`, 8: RAM data width.
- `PATTERN`, 8'h55: background pattern P. The inverse pattern is ~P. Width is DW.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: sampled only in IDLE. A high level launches a test.
- `busy`, out, 1: high while a test runs.
- `done`, out, 1: one-cycle pulse at test end.
- `pass`, out, 1: high when the last test ended with zero mismatches. Held until the next start.
- `err_count`, out, 8: number of mismatches. Saturates at 255.
- `fail_addr`, out, AW: address of the first mismatch.
- `fail_got`, out, DW: data read at the first mismatch.
- `fail_exp`, out, DW: data expected at the first mismatch.
- `ram_en`, out, 1: RAM write enable. 1 = write, 0 = read.
- `ram_addr`, out, AW: RAM address.
- `ram_wdata`, out, DW: RAM write data.
- `ram_rdata`, in, DW: RAM registered read data.

## Operation
- FSM states: IDLE, M0, M1, M2, M3, M4, M5, DONE.
- M0: ascending addresses 0..2^AW-1; write P at each address.
- M1: ascending; at each address read and expect P, then write ~P.
- M2: ascending; at each address read and expect ~P, then write P.
- M3: descending 2^AW-1..0; at each address read and expect P, then write ~P.
- M4: descending; at each address read and expect ~P, then write P.
- M5: descending; read and expect P only.
- Each read or write is one "op" and occupies one cycle. In M1-M4 the read and the write at an address are consecutive ops.
- State transitions:
  - IDLE→M0 when `start` is high.
  - Mi→Mi+1 after the op at the last address of element Mi.
  - M5→DONE after the final compare.
  - DONE→IDLE after one cycle.
- The address counter wraps between elements: it goes to 0 for ascending elements and to 2^AW-1 for descending ones. There is no gap cycle between elements.
- Compare stage:
  - A read issued in op i has its data valid on `ram_rdata` in cycle i+1.
  - A registered compare (expected value and address pipelined by one stage) evaluates it at the end of that cycle.
- On mismatch:
  - `err_count` increments, saturating at 255.
  - `fail_addr`/`fail_got`/`fail_exp` capture the mismatch only if it is the first error of the test.
- At start: `err_count`, `fail_*` and `pass` clear.
- In DONE: `pass` is set to (`err_count` == 0).
- `start` asserted while `busy` is high is ignored.
- Reset mid-test: every output returns to its reset value immediately. `ram_en` drops asynchronously, so no partial write is issued after reset.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_addr`=0, `fail_got`=0, `fail_exp`=0, `ram_en`=0, `ram_addr`=0, `ram_wdata`=0.
- All RAM-side outputs are registered.
- If `start` is sampled high at edge k:
  - `busy` rises after edge k.
  - Op i is driven during the cycle after edge k+1+i.
  - The last op is i = 10·2^AW − 1, i.e. 319 for AW=5.
- `done` is high for the single cycle after edge k + 10·2^AW + 2 (edge k+322 for AW=5). `busy` falls at that same edge.
- `pass` and `err_count` are final when `done` is high.
- When `ram_en` is 0, `ram_wdata` holds its last value. `ram_addr` holds its value outside a test.

## Configuration
- `BIST_STOP_ON_FAIL_EN` defined:
  - On the first mismatch the FSM goes directly to DONE at the compare edge.
  - The op already driven in that cycle completes; at most one trailing write occurs.
  - `err_count` ends at 1, `pass`=0, and `done` pulses one cycle later.
- `BIST_STOP_ON_FAIL_EN` undefined: the full sequence always runs and `err_count` accumulates.

## Test plan
- Fault-free 32x8 RAM, start pulse at edge k:
  - `done` high exactly one cycle after edge k+322.
  - `pass`=1, `err_count`=0.
  - All RAM locations = 8'h55 at the end.
- Bit 0 of address 7 stuck-at-1 (forced in the RAM model), full-run build:
  - First mismatch in M1: `fail_addr`=7, `fail_exp`=8'h55, `fail_got`=8'h55 is impossible; expect the stuck bit to show when ~P=8'hAA is expected, i.e. first failure in M2 with `fail_got`=8'hAB and `fail_exp`=8'hAA.
  - M4 also mismatches, giving `err_count`=2 and `pass`=0.
- Same fault with `BIST_STOP_ON_FAIL_EN`:
  - Test halts in M2 with `err_count`=1 and `fail_addr`=7.
  - `done` pulses well before 322 cycles.
- `rst_n` pulled low during M3 (cycle 200):
  - All outputs return to reset values the same cycle, with `ram_en`=0.
  - A new start then completes with `pass`=1.
- `start` held high for the whole test:
  - A single run completes; `done` pulses once.
  - A second run begins after the cycle in IDLE.
- Every location corrupted by the bench:
  - `err_count` saturates at 255, not wrapping.
  - `fail_addr`=0 from the first M1 read.
